// File: rtl/game_sequencer.sv
// Round scheduler for the fire-dodge game: game-state FSM, LFSR pattern source and per-cell vectors.
// Define GAME_SEQUENCER_GOLD_EN to build the coin logic; otherwise surviving a fire phase scores.
module game_sequencer #(
  parameter int          LIFE_MAX     = 3,
  parameter int          SCORE_MAX    = 5,
  parameter int          WARN_TICKS   = 4,
  parameter int          FIRE_TICKS   = 2,
  parameter int          FINISH_TICKS = 8,
  parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       start,
  input  logic [8:0] box,
  output logic [1:0] game_state,
  output logic [8:0] fire_state,
  output logic [8:0] gold_state,
  output logic [8:0] next_fire_pattern,
  output logic [8:0] hit_bitmap,
  output logic [1:0] life,
  output logic [3:0] score,
  output logic       win
);

  localparam logic [1:0] S_INIT   = 2'b00;
  localparam logic [1:0] S_WARN   = 2'b01;
  localparam logic [1:0] S_FIRE   = 2'b11;
  localparam logic [1:0] S_FINISH = 2'b10;

  logic [1:0]  state_reg, state_next;
  logic [1:0]  game_state_reg, game_state_next;
  logic [15:0] lfsr_reg, lfsr_next;
  logic [7:0]  tick_cnt_reg, tick_cnt_next;
  logic [8:0]  fire_reg, fire_next;
  logic [8:0]  pattern_reg, pattern_next;
  logic [8:0]  hit_reg, hit_next;
  logic [1:0]  life_reg, life_next;
  logic [3:0]  score_reg, score_next;
  logic        win_reg, win_next;

  logic        lfsr_fb;
  logic [8:0]  pattern_raw;
  logic [8:0]  setup_pattern;
  logic [8:0]  hit_vec;
  logic [3:0]  score_inc;
  logic [7:0]  phase_len;
  logic        phase_end;

  // Fibonacci taps 16,14,13,11 expressed as zero-based bit positions.
  assign lfsr_fb = lfsr_reg[15] ^ lfsr_reg[13] ^ lfsr_reg[12] ^ lfsr_reg[10];

  // All-clear and all-burning rounds are not playable, so substitute the centre cell.
  assign pattern_raw   = lfsr_reg[8:0];
  assign setup_pattern = (pattern_raw == 9'h000 || pattern_raw == 9'h1FF) ? 9'h010 : pattern_raw;

  assign hit_vec   = box & pattern_reg;
  assign score_inc = (score_reg == 4'hF) ? 4'hF : score_reg + 4'd1;

  always_comb begin
    phase_len = 8'd1;
    case (state_reg)
      S_WARN:   phase_len = 8'(WARN_TICKS);
      S_FIRE:   phase_len = 8'(FIRE_TICKS);
      S_FINISH: phase_len = 8'(FINISH_TICKS);
      default:  phase_len = 8'd1;
    endcase
  end

  assign phase_end = tick && (state_reg != S_INIT) && (tick_cnt_reg == phase_len - 8'd1);

`ifdef GAME_SEQUENCER_GOLD_EN
  logic [8:0] gold_reg, gold_next;
  logic [3:0] coin_idx;
  logic [8:0] coin_onehot;
  logic [8:0] setup_gold;

  assign coin_idx = (lfsr_reg[15:12] >= 4'd9) ? lfsr_reg[15:12] - 4'd9 : lfsr_reg[15:12];

  genvar gi;
  generate
    for (gi = 0; gi < 9; gi++) begin : g_coin
      assign coin_onehot[gi] = (coin_idx == 4'(gi));
    end
  endgenerate

  // A coin under a burning cell would be uncollectable, so that round has none.
  assign setup_gold = ((coin_onehot & setup_pattern) != 9'h000) ? 9'h000 : coin_onehot;
  assign gold_state = gold_reg;
`else
  assign gold_state = 9'h000;
`endif

  always_comb begin
    state_next      = state_reg;
    game_state_next = game_state_reg;
    lfsr_next       = {lfsr_reg[14:0], lfsr_fb};
    tick_cnt_next   = tick_cnt_reg;
    fire_next       = fire_reg;
    pattern_next    = pattern_reg;
    hit_next        = hit_reg;
    life_next       = life_reg;
    score_next      = score_reg;
    win_next        = win_reg;
`ifdef GAME_SEQUENCER_GOLD_EN
    gold_next       = gold_reg;
`endif

    // Counter restarts on every phase change, so an entry-edge tick is never counted.
    if (tick && state_reg != S_INIT)
      tick_cnt_next = phase_end ? 8'd0 : tick_cnt_reg + 8'd1;

    case (state_reg)
      S_INIT: begin
        tick_cnt_next = 8'd0;
        if (start) begin
          state_next      = S_WARN;
          game_state_next = 2'b01;
          life_next       = 2'(LIFE_MAX);
          score_next      = 4'd0;
          win_next        = 1'b0;
          pattern_next    = setup_pattern;
`ifdef GAME_SEQUENCER_GOLD_EN
          gold_next       = setup_gold;
`endif
        end
      end

      S_WARN: begin
`ifdef GAME_SEQUENCER_GOLD_EN
        if ((box & gold_reg) != 9'h000) begin
          score_next = score_inc;
          gold_next  = 9'h000;
        end
`endif
        if (phase_end) begin
          state_next = S_FIRE;
          fire_next  = pattern_reg;
          hit_next   = hit_vec;
          if (hit_vec != 9'h000)
            life_next = (life_reg != 2'd0) ? life_reg - 2'd1 : 2'd0;
`ifndef GAME_SEQUENCER_GOLD_EN
          else
            score_next = score_inc;
`endif
`ifdef GAME_SEQUENCER_GOLD_EN
          gold_next = 9'h000;
`endif
        end
      end

      S_FIRE: begin
        if (phase_end) begin
          fire_next = 9'h000;
          hit_next  = 9'h000;
          if (life_reg == 2'd0) begin
            state_next      = S_FINISH;
            game_state_next = 2'b10;
            win_next        = 1'b0;
            pattern_next    = 9'h000;
          end else if (score_reg >= 4'(SCORE_MAX)) begin
            state_next      = S_FINISH;
            game_state_next = 2'b10;
            win_next        = 1'b1;
            pattern_next    = 9'h000;
          end else begin
            state_next   = S_WARN;
            pattern_next = setup_pattern;
`ifdef GAME_SEQUENCER_GOLD_EN
            gold_next    = setup_gold;
`endif
          end
        end
      end

      S_FINISH: begin
        if (phase_end) begin
          state_next      = S_INIT;
          game_state_next = 2'b00;
          life_next       = 2'd0;
          score_next      = 4'd0;
          win_next        = 1'b0;
        end
      end

      default: begin
        state_next      = S_INIT;
        game_state_next = 2'b00;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg      <= S_INIT;
      game_state_reg <= 2'b00;
      lfsr_reg       <= LFSR_SEED;
      tick_cnt_reg   <= 8'd0;
      fire_reg       <= 9'h000;
      pattern_reg    <= 9'h000;
      hit_reg        <= 9'h000;
      life_reg       <= 2'd0;
      score_reg      <= 4'd0;
      win_reg        <= 1'b0;
`ifdef GAME_SEQUENCER_GOLD_EN
      gold_reg       <= 9'h000;
`endif
    end else begin
      state_reg      <= state_next;
      game_state_reg <= game_state_next;
      lfsr_reg       <= lfsr_next;
      tick_cnt_reg   <= tick_cnt_next;
      fire_reg       <= fire_next;
      pattern_reg    <= pattern_next;
      hit_reg        <= hit_next;
      life_reg       <= life_next;
      score_reg      <= score_next;
      win_reg        <= win_next;
`ifdef GAME_SEQUENCER_GOLD_EN
      gold_reg       <= gold_next;
`endif
    end
  end

  assign game_state        = game_state_reg;
  assign fire_state        = fire_reg;
  assign next_fire_pattern = pattern_reg;
  assign hit_bitmap        = hit_reg;
  assign life              = life_reg;
  assign score             = score_reg;
  assign win               = win_reg;

endmodule
